// File: rtl/usb_tx_pkg.sv
// Shared transmit-path definitions: field lengths, the one-hot field vector
// and a length lookup used by the bit scheduler.
package usb_tx_pkg;

  localparam int SYNC_LEN  = 8;
  localparam int PID_LEN   = 8;
  localparam int CRC5_LEN  = 5;
  localparam int CRC16_LEN = 16;
  localparam int DATA_LEN  = 64;

  typedef struct packed {
    logic data;
    logic crc16;
    logic crc5;
    logic pid;
    logic sync;
  } tx_field_t;

  // Only meaningful for a one-hot vector; an empty vector yields 0.
  function automatic logic [6:0] field_len(input tx_field_t f);
    logic [6:0] len;
    len = '0;
    if (f.sync)  len = 7'(SYNC_LEN);
    if (f.pid)   len = 7'(PID_LEN);
    if (f.crc5)  len = 7'(CRC5_LEN);
    if (f.crc16) len = 7'(CRC16_LEN);
    if (f.data)  len = 7'(DATA_LEN);
    return len;
  endfunction

endpackage

// File: rtl/bit_period_divider.sv
// Rollover counter 0..PERIOD-1 with synchronous clear and enable; the
// terminal-count flag is decoded from the count register alone.
module bit_period_divider #(
  parameter int PERIOD = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] clk_cnt_q;
  logic [W-1:0] clk_cnt_d;
  logic [W-1:0] base;

  // A clear cycle counts as position 0 of the new period, so the count
  // continues from 0 rather than losing a cycle.
  always_comb begin
    base      = clear ? '0 : clk_cnt_q;
    clk_cnt_d = '0;
    if (enable) begin
      clk_cnt_d = (base == LAST) ? '0 : base + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      clk_cnt_q <= '0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
    end
  end

  assign tc = (clk_cnt_q == LAST);

endmodule

// File: rtl/tx_bit_scheduler.sv
// Bit-period strobe generator and per-field bit counter for the USB transmit
// path; issues one-cycle done pulses back to the transmit control unit.
module tx_bit_scheduler
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       sync_transmitting,
  input  logic       pid_transmitting,
  input  logic       crc5_transmitting,
  input  logic       crc16_transmitting,
  input  logic       data_transmitting,
  input  logic       idle_transmitting,
  input  logic       stuff_insert,
  output logic       shift_enable,
  output logic [6:0] bit_index,
  output logic       sync_bits_transmitted,
  output logic       pid_bits_transmitted,
  output logic       crc5_bits_transmitted,
  output logic       crc16_bits_transmitted,
  output logic       data_bits_transmitted,
  output logic       field_error
);

  tx_field_t  field_now;
  tx_field_t  prev_field_q, prev_field_d;
  tx_field_t  done_q, done_d;
  logic [5:0] bit_cnt_q, bit_cnt_d;
  logic       done_hold_q, done_hold_d;
  logic       field_error_q, field_error_d;
  logic       cur_active, prev_active, field_multi, field_change;
  logic       div_enable, div_tc;
  logic [6:0] cur_len;

  assign field_now = {data_transmitting, crc16_transmitting, crc5_transmitting,
                      pid_transmitting, sync_transmitting};

  assign cur_active   = $onehot(field_now);
  assign prev_active  = $onehot(prev_field_q);
  assign field_multi  = (field_now != '0) && !cur_active;
  assign field_change = (field_now != prev_field_q);

  // A new field may start while done_hold is still set from the previous one.
  assign div_enable = cur_active && (field_change || !done_hold_q);

  bit_period_divider #(
    .PERIOD(CLKS_PER_BIT)
  ) u_divider (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (field_change),
    .enable(div_enable),
    .tc    (div_tc)
  );

  assign shift_enable = prev_active && !done_hold_q && div_tc;

  always_comb begin
    prev_field_d  = field_now;
    bit_cnt_d     = bit_cnt_q;
    done_hold_d   = done_hold_q;
    done_d        = '0;
    field_error_d = field_error_q;
    cur_len       = field_len(prev_field_q);

    if (field_multi) begin
      field_error_d = 1'b1;
    end else if (idle_transmitting && (field_now == '0)) begin
      field_error_d = 1'b0;
    end

    if (field_change) begin
      bit_cnt_d   = '0;
      done_hold_d = 1'b0;
    end else if (!cur_active) begin
      bit_cnt_d = '0;
    end else if (shift_enable) begin
      if (stuff_insert) begin
        bit_cnt_d = bit_cnt_q;
      end else if ({1'b0, bit_cnt_q} < cur_len - 7'd1) begin
        bit_cnt_d = bit_cnt_q + 6'd1;
      end else begin
        bit_cnt_d   = '0;
        done_hold_d = 1'b1;
        done_d      = prev_field_q;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_field_q  <= '0;
      done_q        <= '0;
      bit_cnt_q     <= '0;
      done_hold_q   <= 1'b0;
      field_error_q <= 1'b0;
    end else begin
      prev_field_q  <= prev_field_d;
      done_q        <= done_d;
      bit_cnt_q     <= bit_cnt_d;
      done_hold_q   <= done_hold_d;
      field_error_q <= field_error_d;
    end
  end

  assign bit_index              = {1'b0, bit_cnt_q};
  assign sync_bits_transmitted  = done_q.sync;
  assign pid_bits_transmitted   = done_q.pid;
  assign crc5_bits_transmitted  = done_q.crc5;
  assign crc16_bits_transmitted = done_q.crc16;
  assign data_bits_transmitted  = done_q.data;
  assign field_error            = field_error_q;

endmodule

// File: tb/tb_tx_bit_scheduler.sv
// Directed bench: whole-field vectors from a table plus hand-written
// sequences for reset, back-to-back fields and field conflicts.
module tb_tx_bit_scheduler;

  logic clk = 1'b0;
  logic n_rst;
  logic sync_t, pid_t, crc5_t, crc16_t, data_t, idle_t, stuff;

  logic       se4, se8, fe4, fe8;
  logic [6:0] bi4, bi8;
  logic [4:0] dn4, dn8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tx_bit_scheduler #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .n_rst(n_rst),
    .sync_transmitting(sync_t), .pid_transmitting(pid_t),
    .crc5_transmitting(crc5_t), .crc16_transmitting(crc16_t),
    .data_transmitting(data_t), .idle_transmitting(idle_t),
    .stuff_insert(stuff), .shift_enable(se4), .bit_index(bi4),
    .sync_bits_transmitted(dn4[0]), .pid_bits_transmitted(dn4[1]),
    .crc5_bits_transmitted(dn4[2]), .crc16_bits_transmitted(dn4[3]),
    .data_bits_transmitted(dn4[4]), .field_error(fe4)
  );

  tx_bit_scheduler #(.CLKS_PER_BIT(8)) dut8 (
    .clk(clk), .n_rst(n_rst),
    .sync_transmitting(sync_t), .pid_transmitting(pid_t),
    .crc5_transmitting(crc5_t), .crc16_transmitting(crc16_t),
    .data_transmitting(data_t), .idle_transmitting(idle_t),
    .stuff_insert(stuff), .shift_enable(se8), .bit_index(bi8),
    .sync_bits_transmitted(dn8[0]), .pid_bits_transmitted(dn8[1]),
    .crc5_bits_transmitted(dn8[2]), .crc16_bits_transmitted(dn8[3]),
    .data_bits_transmitted(dn8[4]), .field_error(fe8)
  );

  typedef struct {
    logic [4:0] fld;    // {data, crc16, crc5, pid, sync}
    int         len;
    int         s0;     // strobe cycle carrying a stuffed bit, -1 for none
    int         s1;
    bit         use8;
    int         run;
    int         pulse;  // expected done-pulse cycle
    logic [4:0] done;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic chk(input string name, input int tag, input int cyc,
                     input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s vec=%0d cyc=%0d got=%0d exp=%0d", name, tag, cyc, got, exp);
    end
  endtask

  task automatic set_fields(input logic [4:0] f);
    {data_t, crc16_t, crc5_t, pid_t, sync_t} = f;
  endtask

  // Called at posedge+1; leaves the bench at posedge+1.
  task automatic idle_gap(input int n);
    set_fields(5'b0);
    idle_t = 1'b1;
    stuff  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    idle_t = 1'b0;
  endtask

  initial begin
    vecs[0] = '{5'b00001, 8,  -1, -1, 1'b0, 41,  32,  5'b00001};
    vecs[1] = '{5'b00010, 8,  -1, -1, 1'b0, 36,  32,  5'b00010};
    vecs[2] = '{5'b00100, 5,  11, -1, 1'b0, 28,  24,  5'b00100};
    vecs[3] = '{5'b00100, 5,  19, -1, 1'b0, 28,  24,  5'b00100};
    vecs[4] = '{5'b01000, 16, -1, -1, 1'b0, 68,  64,  5'b01000};
    vecs[5] = '{5'b01000, 16, 7,  11, 1'b0, 76,  72,  5'b01000};
    vecs[6] = '{5'b10000, 64, -1, -1, 1'b1, 516, 512, 5'b10000};

    n_rst = 1'b0;
    set_fields(5'b0);
    idle_t = 1'b0;
    stuff  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_se4", -1, 0, int'(se4), 0);
    chk("rst_bi4", -1, 0, int'(bi4), 0);
    chk("rst_dn4", -1, 0, int'(dn4), 0);
    chk("rst_fe4", -1, 0, int'(fe4), 0);
    chk("rst_se8", -1, 0, int'(se8), 0);
    chk("rst_bi8", -1, 0, int'(bi8), 0);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    idle_gap(3);

    for (int r = 0; r < NV; r++) begin
      int n, ns, idx;
      logic se, fe;
      logic [6:0] bi;
      logic [4:0] dn;
      n   = vecs[r].use8 ? 8 : 4;
      ns  = vecs[r].len + ((vecs[r].s0 >= 0) ? 1 : 0) + ((vecs[r].s1 >= 0) ? 1 : 0);
      idx = 0;
      for (int c = 0; c < vecs[r].run; c++) begin
        bit exp_se;
        set_fields(vecs[r].fld);
        stuff = (c == vecs[r].s0) || (c == vecs[r].s1);
        @(negedge clk);
        se = vecs[r].use8 ? se8 : se4;
        bi = vecs[r].use8 ? bi8 : bi4;
        dn = vecs[r].use8 ? dn8 : dn4;
        fe = vecs[r].use8 ? fe8 : fe4;
        exp_se = (((c + 1) % n) == 0) && (((c + 1) / n) <= ns);
        chk("shift_enable", r, c, int'(se), int'(exp_se));
        chk("bit_index", r, c, int'(bi), idx);
        chk("done", r, c, int'(dn), (c == vecs[r].pulse) ? int'(vecs[r].done) : 0);
        chk("field_error", r, c, int'(fe), 0);
        if (exp_se && !stuff) begin
          idx++;
          if (idx == vecs[r].len) idx = 0;
        end
        @(posedge clk);
        #1;
      end
      idle_gap(3);
    end

    // Back-to-back PID then CRC5.
    for (int c = 0; c <= 40; c++) begin
      bit exp_se;
      set_fields((c <= 32) ? 5'b00010 : 5'b00100);
      @(negedge clk);
      exp_se = (c <= 31 && ((c + 1) % 4) == 0) || c == 36 || c == 40;
      chk("b2b_shift_enable", 10, c, int'(se4), int'(exp_se));
      chk("b2b_done", 10, c, int'(dn4), (c == 32) ? 2 : 0);
      if (c >= 32) chk("b2b_bit_index", 10, c, int'(bi4), (c >= 37) ? 1 : 0);
      @(posedge clk);
      #1;
    end
    idle_gap(3);

    // PID with DATA overlapping in cycles 5..9, then idle clears the error.
    for (int c = 0; c <= 19; c++) begin
      set_fields({(c >= 5 && c <= 9), 2'b00, (c <= 14), 1'b0});
      idle_t = (c >= 17);
      @(negedge clk);
      chk("conf_field_error", 11, c, int'(fe4), (c >= 6 && c <= 17) ? 1 : 0);
      chk("conf_done", 11, c, int'(dn4), 0);
      if (c == 3) chk("conf_shift_enable", 11, c, int'(se4), 1);
      if (c >= 5 && c <= 12) chk("conf_shift_enable", 11, c, int'(se4), 0);
      if (c >= 6 && c <= 12) chk("conf_bit_index", 11, c, int'(bi4), 0);
      @(posedge clk);
      #1;
    end
    idle_gap(3);

    // Reset asserted mid-SYNC, then released with SYNC still high.
    for (int c = 0; c <= 9; c++) begin
      set_fields(5'b00001);
      @(negedge clk);
      if (c == 9) chk("pre_rst_bit_index", 12, c, int'(bi4), 2);
      @(posedge clk);
      #1;
    end
    n_rst = 1'b0;
    #1;
    chk("async_rst_se", 12, 10, int'(se4), 0);
    chk("async_rst_bi", 12, 10, int'(bi4), 0);
    chk("async_rst_dn", 12, 10, int'(dn4), 0);
    chk("async_rst_fe", 12, 10, int'(fe4), 0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_shift_enable", 12, c, int'(se4), (c == 3) ? 1 : 0);
      chk("post_rst_bit_index", 12, c, int'(bi4), (c >= 4) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
